led_fader: RTL and testbench

Downstream stage of the LED blink counter. It takes the counter's toggling LED level as a target on/off request and drives the physical LED with an 8-bit PWM signal. Brightness ramps up and down linearly instead of switching hard, giving a "breathing" blink. Sits between the blink counter and the board LED pin, in the same `CLK` domain.

---
 rtl/led_pkg.sv | 18 +
 rtl/led_fader_if.sv | 32 +++
 rtl/pwm_gen.sv | 37 +++
 rtl/led_fader.sv | 108 ++++++++++
 tb/tb_led_fader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types and default constants for the LED fader slice.
package led_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } fade_state_t;

  localparam int LED_PWM_BITS = 8;
  localparam int LED_STEP_DIV = 3906;

  function automatic logic is_ramping(input fade_state_t st);
    return (st == RISE) || (st == FALL);
  endfunction

endpackage

// File: rtl/led_fader_if.sv
// Signal bundle between the blink counter side and the LED fader.
// LEVEL_IN is a plain level (no handshake): the fader samples it every cycle and
// the outputs are registered levels valid on every cycle after reset.
interface led_fader_if
  import led_pkg::*;
#(
  parameter int PWM_BITS = LED_PWM_BITS
);

  logic                LEVEL_IN;
  logic                LED_PWM;
  logic [PWM_BITS-1:0] BRIGHTNESS;
  logic                BUSY;
  fade_state_t         dbg_state;

  modport master (
    output LEVEL_IN,
    input  LED_PWM,
    input  BRIGHTNESS,
    input  BUSY,
    input  dbg_state
  );

  modport slave (
    input  LEVEL_IN,
    output LED_PWM,
    output BRIGHTNESS,
    output BUSY,
    output dbg_state
  );

endinterface

// File: rtl/pwm_gen.sv
// Free-running PWM counter over 0..MAX-1 with a registered (counter < duty) output,
// so duty 0 is always low, duty MAX is always high, and duty d gives d high cycles.
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm
);

  localparam logic [PWM_BITS-1:0] P_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PWM_BITS-1:0] p_q, p_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    p_d   = p_q + PWM_BITS'(1);
    if (p_q == P_LAST) begin
      p_d = '0;
    end
    pwm_d = (p_q < duty);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      p_q   <= '0;
      pwm_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/led_fader.sv
// Breathing LED driver: ramps brightness linearly toward the requested level,
// one step every STEP_DIV cycles, and drives the pin through pwm_gen.
module led_fader
  import led_pkg::*;
#(
  parameter int PWM_BITS = LED_PWM_BITS,
  parameter int STEP_DIV = LED_STEP_DIV
) (
  input  logic        CLK,
  input  logic        RST_N,
  led_fader_if.slave  io
);

  localparam int                  S_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [S_W-1:0]      S_LAST = S_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] B_MAX  = '1;

  fade_state_t         state_q, state_d;
  logic                lvl_q, lvl_d;
  logic [PWM_BITS-1:0] b_q, b_d;
  logic [S_W-1:0]      s_q, s_d;
  logic                tick;
  logic [PWM_BITS-1:0] b_inc, b_dec;

  assign tick  = (s_q == S_LAST);
  assign b_inc = b_q + PWM_BITS'(1);
  assign b_dec = b_q - PWM_BITS'(1);
  assign lvl_d = io.LEVEL_IN;

  // The prescaler restarts from zero on every state change so a reversal
  // discards the partial step instead of carrying it into the new direction.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    s_d     = '0;
    unique case (state_q)
      OFF: begin
        if (lvl_q) begin
          state_d = RISE;
        end
      end
      RISE: begin
        if (!lvl_q) begin
          state_d = FALL;
        end else if (b_q == B_MAX) begin
          state_d = ON;
        end else if (tick) begin
          b_d = b_inc;
          if (b_inc == B_MAX) begin
            state_d = ON;
          end
        end else begin
          s_d = s_q + S_W'(1);
        end
      end
      ON: begin
        if (!lvl_q) begin
          state_d = FALL;
        end
      end
      FALL: begin
        if (lvl_q) begin
          state_d = RISE;
        end else if (b_q == '0) begin
          state_d = OFF;
        end else if (tick) begin
          b_d = b_dec;
          if (b_dec == '0) begin
            state_d = OFF;
          end
        end else begin
          s_d = s_q + S_W'(1);
        end
      end
      default: begin
        state_d = OFF;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= OFF;
      lvl_q   <= 1'b0;
      b_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      b_q     <= b_d;
      s_q     <= s_d;
    end
  end

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .CLK   (CLK),
    .RST_N (RST_N),
    .duty  (b_q),
    .pwm   (io.LED_PWM)
  );

  assign io.BRIGHTNESS = b_q;
  assign io.BUSY       = is_ramping(state_q);
  assign io.dbg_state  = state_q;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader: a fast instance (MAX=15, STEP_DIV=2) for ramp
// timing, reversal, reset and glitch cases, and a slow instance for duty accuracy.
module tb_led_fader;
  import led_pkg::*;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  logic rst_n_d;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  led_fader_if #(.PWM_BITS(W)) a_if ();
  led_fader_if #(.PWM_BITS(W)) d_if ();

  led_fader #(.PWM_BITS(W), .STEP_DIV(2)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .io    (a_if)
  );

  led_fader #(.PWM_BITS(W), .STEP_DIV(1000)) dut_duty (
    .CLK   (clk),
    .RST_N (rst_n_d),
    .io    (d_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pops one expected brightness whenever the DUT output moves.
  task automatic sb_track(inout logic [W-1:0] prev);
    logic [W-1:0] e;
    if (a_if.BRIGHTNESS !== prev) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_step", 32'(a_if.BRIGHTNESS), 32'(prev));
      end else begin
        e = exp_q.pop_front();
        check("sb_bright", 32'(a_if.BRIGHTNESS), 32'(e));
      end
      prev = a_if.BRIGHTNESS;
    end
  endtask

  // Called on the cycle RISE has just been entered from B=0.
  task automatic ramp_up_check(input string tag);
    logic [W-1:0] prev;
    prev = '0;
    for (int i = 1; i <= 15; i++) exp_q.push_back(W'(i));
    for (int c = 1; c <= 30; c++) begin
      step();
      check({tag, "_bright"}, 32'(a_if.BRIGHTNESS), 32'(c / 2));
      check({tag, "_busy"}, 32'(a_if.BUSY), (c < 30) ? 32'd1 : 32'd0);
      sb_track(prev);
    end
    check({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_state_on"}, 32'(a_if.dbg_state), 32'(ON));
    for (int c = 0; c < 16; c++) begin
      step();
      check({tag, "_pwm_full"}, 32'(a_if.LED_PWM), 32'd1);
    end
  endtask

  task automatic wait_bright_a(input logic [W-1:0] t, input int limit, input string tag);
    int n;
    n = 0;
    while (a_if.BRIGHTNESS !== t && n < limit) begin
      step();
      n++;
    end
    check({tag, "_reached"}, 32'(a_if.BRIGHTNESS), 32'(t));
  endtask

  task automatic duty_window(input logic [W-1:0] t, input string tag);
    int n;
    int cnt;
    n = 0;
    while (d_if.BRIGHTNESS !== t && n < 20000) begin
      step();
      n++;
    end
    check({tag, "_reached"}, 32'(d_if.BRIGHTNESS), 32'(t));
    step();
    step();
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      cnt += int'(d_if.LED_PWM);
    end
    check({tag, "_high_count"}, 32'(cnt), 32'(t));
    check({tag, "_steady"}, 32'(d_if.BRIGHTNESS), 32'(t));
  endtask

  initial begin
    logic [W-1:0] prev;
    logic [W-1:0] peak;
    int cnt;

    rst_n       = 1'b0;
    rst_n_d     = 1'b0;
    a_if.LEVEL_IN = 1'b1;
    d_if.LEVEL_IN = 1'b0;

    // reset hold
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_pwm", 32'(a_if.LED_PWM), 32'd0);
      check("rst_bright", 32'(a_if.BRIGHTNESS), 32'd0);
      check("rst_busy", 32'(a_if.BUSY), 32'd0);
    end

    // fade on
    a_if.LEVEL_IN = 1'b0;
    rst_n = 1'b1;
    step(); step(); step();
    check("idle_state", 32'(a_if.dbg_state), 32'(OFF));
    a_if.LEVEL_IN = 1'b1;
    step();
    check("on_busy_k", 32'(a_if.BUSY), 32'd0);
    step();
    check("on_busy_k1", 32'(a_if.BUSY), 32'd1);
    check("on_entry_bright", 32'(a_if.BRIGHTNESS), 32'd0);
    ramp_up_check("fade_on");

    // reversal at B=7
    rst_n = 1'b0;
    a_if.LEVEL_IN = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    a_if.LEVEL_IN = 1'b1;
    step();
    step();
    wait_bright_a(W'(7), 40, "rev_rise");
    a_if.LEVEL_IN = 1'b0;
    step();
    check("rev_hold1", 32'(a_if.BRIGHTNESS), 32'd7);
    step();
    check("rev_hold2", 32'(a_if.BRIGHTNESS), 32'd7);
    check("rev_fall_state", 32'(a_if.dbg_state), 32'(FALL));
    for (int i = 6; i >= 0; i--) exp_q.push_back(W'(i));
    prev = W'(7);
    peak = W'(7);
    for (int c = 1; c <= 14; c++) begin
      step();
      if (a_if.BRIGHTNESS > peak) peak = a_if.BRIGHTNESS;
      check("rev_bright", 32'(a_if.BRIGHTNESS), 32'(7 - c / 2));
      check("rev_busy", 32'(a_if.BUSY), (c < 14) ? 32'd1 : 32'd0);
      sb_track(prev);
    end
    check("rev_peak", 32'(peak), 32'd7);
    check("rev_sb_drained", 32'(exp_q.size()), 32'd0);
    check("rev_state_off", 32'(a_if.dbg_state), 32'(OFF));

    // reset mid-ramp at B=9
    a_if.LEVEL_IN = 1'b1;
    step();
    step();
    wait_bright_a(W'(9), 40, "mid_rise");
    rst_n = 1'b0;
    step();
    check("mid_rst_bright", 32'(a_if.BRIGHTNESS), 32'd0);
    check("mid_rst_busy", 32'(a_if.BUSY), 32'd0);
    check("mid_rst_pwm", 32'(a_if.LED_PWM), 32'd0);
    rst_n = 1'b1;
    step();
    check("mid_rel_busy0", 32'(a_if.BUSY), 32'd0);
    step();
    check("mid_rel_busy1", 32'(a_if.BUSY), 32'd1);
    check("mid_rel_bright", 32'(a_if.BRIGHTNESS), 32'd0);
    ramp_up_check("restart");

    // glitch pulse while OFF
    rst_n = 1'b0;
    a_if.LEVEL_IN = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    a_if.LEVEL_IN = 1'b1;
    step();
    a_if.LEVEL_IN = 1'b0;
    step();
    check("gl_busy1", 32'(a_if.BUSY), 32'd1);
    step();
    check("gl_busy2", 32'(a_if.BUSY), 32'd1);
    check("gl_state_fall", 32'(a_if.dbg_state), 32'(FALL));
    step();
    check("gl_busy_end", 32'(a_if.BUSY), 32'd0);
    check("gl_state_off", 32'(a_if.dbg_state), 32'(OFF));
    for (int i = 0; i < 8; i++) begin
      check("gl_bright", 32'(a_if.BRIGHTNESS), 32'd0);
      check("gl_pwm", 32'(a_if.LED_PWM), 32'd0);
      check("gl_busy_idle", 32'(a_if.BUSY), 32'd0);
      step();
    end

    // duty accuracy on the slow instance
    rst_n_d = 1'b1;
    step();
    d_if.LEVEL_IN = 1'b1;
    step();
    step();
    check("duty_busy", 32'(d_if.BUSY), 32'd1);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      cnt += int'(d_if.LED_PWM);
    end
    check("duty0_high_count", 32'(cnt), 32'd0);
    duty_window(W'(1), "duty1");
    duty_window(W'(7), "duty7");
    duty_window(W'(14), "duty14");
    duty_window(W'(15), "duty15");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
